vic_reg_bridge: RTL and testbench
=================================

# vic_reg_bridge

Host-side initiator for the VIC nibble register file: accepts byte-wide CPU register accesses (16 byte registers) and turns each into two sequenced 4-bit accesses (low nibble, then high nibble) on the `vic_registers` port. The bridge sits between the 6502 bus decode and `vic_registers`. It is the only driver of that block's `i_VIC_regaddr`, `i_VIC_data`, `i_VIC_we` and `i_VIC_re` inputs.

## Interface
- `READ_LAT`, default 1: cycles from the `o_VIC_re` cycle until `i_VIC_data` is valid; legal range 1–3.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_cpu_req`  in  1  single-cycle request strobe; sampled only in IDLE.
- `i_cpu_wr`  in  1  1 = write, 0 = read; qualified by `i_cpu_req`.
- `i_cpu_addr`  in  4  byte register index 0–15.
- `i_cpu_wdata`  in  8  write byte; qualified by `i_cpu_req`.
- `o_cpu_rdata`  out  8  last completed read byte; holds until the next read completes.
- `o_cpu_ack`  out  1  one-cycle completion pulse.
- `o_busy`  out  1  high in every non-IDLE state.
- `o_VIC_regaddr`  out  5  nibble address.
- `o_VIC_data`  out  4  write nibble.
- `i_VIC_data`  in  4  read nibble from the register file.
- `o_VIC_we`  out  1  nibble write enable.
- `o_VIC_re`  out  1  nibble read enable.

## Operation
- Nibble mapping: byte register n maps to nibble 2n (bits 3:0) and nibble 2n+1 (bits 7:4). `o_VIC_regaddr = {addr, 0}` for the low nibble and `{addr, 1}` for the high nibble.
- The FSM has the states IDLE, WR_LO, WR_HI, RD_LO, RD_LO_W, RD_HI, RD_HI_W, ACK.
- IDLE:
  - On `i_cpu_req`, latch addr, wr and wdata.
  - Go to WR_LO if wr = 1, otherwise to RD_LO.
- WR_LO drives `o_VIC_we` = 1 with the low nibble, then goes to WR_HI.
- WR_HI drives `o_VIC_we` = 1 with the high nibble, then goes to ACK.
- RD_LO drives `o_VIC_re` = 1 for one cycle at nibble 2n, then goes to RD_LO_W.
- RD_LO_W:
  - A 2-bit wait counter runs READ_LAT cycles.
  - The bridge samples `i_VIC_data` into the low half of a capture register on the last wait cycle, then goes to RD_HI.
- RD_HI and RD_HI_W are the same as RD_LO and RD_LO_W, at nibble 2n+1 and capturing into the high half.
- RD_HI_W then goes to ACK.
- ACK:
  - `o_cpu_ack` = 1.
  - For a read, `o_cpu_rdata` is updated from the capture register when ACK is entered.
  - Always returns to IDLE.
- `o_VIC_we` and `o_VIC_re` are never high in the same cycle, and are never high outside the states listed above.
- `o_VIC_regaddr` and `o_VIC_data` are don't-care while both enables are low; the implementation holds their last value.
- A request arriving while `o_busy` = 1, including in the ACK cycle, is dropped with no ack. The CPU side must wait for `o_busy` = 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - A write interrupted after WR_LO leaves only the low nibble updated. This is accepted behaviour; there is no rollback.

## Timing
- Reset values: `o_cpu_rdata` = 8'h00; `o_cpu_ack`, `o_busy`, `o_VIC_we` and `o_VIC_re` = 0; `o_VIC_regaddr` = 0; `o_VIC_data` = 0; state = IDLE.
- All outputs are registered or decoded from registered state; there are no combinational paths from `i_cpu_*` to outputs.
- Write (cycle 0 = the edge where the req is sampled):
  - cycle 1: WE at low nibble.
  - cycle 2: WE at high nibble.
  - cycle 3: ack.
  - Next accept is possible at cycle 4.
- Read:
  - RE at low nibble in cycle 1.
  - RE at high nibble in cycle 2+READ_LAT.
  - Ack and `o_cpu_rdata` valid in cycle 3+2·READ_LAT (cycle 5 for READ_LAT = 1).
- Back-to-back requests: one IDLE cycle between consecutive accesses is mandatory.

## Structure
- `vic_pkg` holds:
  - the FSM state encoding;
  - `VIC_NIBBLES` = 32 and `VIC_BYTE_REGS` = 16;
  - the nibble-address function `{byte_idx, hi_sel}`, shared with `vic_registers` so the mapping cannot diverge.
- Single module; no sub-module is warranted. The wait counter and capture register stay inline.

## Test plan
- Reset then idle: after `rst` deasserts, all outputs are 0 and `o_busy` = 0 for 10 cycles with no req.
- Write addr 4'h5, data 8'hA7:
  - cycle 1: we = 1, regaddr = 10, data = 4'h7.
  - cycle 2: we = 1, regaddr = 11, data = 4'hA.
  - cycle 3: ack = 1.
  - A `vic_registers` model then holds 8'hA7 in byte 5.
- Read after write: read addr 4'h5 with READ_LAT = 1 → re at cycles 1 and 3 (regaddr 10, then 11), ack at cycle 5, `o_cpu_rdata` = 8'hA7 and held afterwards.
- Full sweep: write $random bytes to addrs 0–15, read all back → every byte matches; nibble addresses 0–31 are each hit exactly once per pass.
- Busy drop: issue a req at cycle 2 of a write → exactly one ack and no extra we/re pulses; a req in the ACK cycle is also dropped.
- Reset mid-write: assert `rst` during WR_HI → outputs go to 0 asynchronously, state = IDLE, nibble 2n holds the new value and nibble 2n+1 the old one; the next read completes normally.

Source files
------------

// File: rtl/vic_pkg.sv
// vic_pkg: shared definitions for the VIC nibble register file and its host bridge.
//   - vic_state_e     : bridge FSM state encoding
//   - VIC_NIBBLES     : number of 4-bit registers in the register file
//   - VIC_BYTE_REGS   : number of CPU-visible byte registers
//   - vic_nibble_addr : byte index + half select -> nibble address; used by both
//                       sides so the byte/nibble mapping cannot drift apart.
package vic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_LO   = 3'd1,
        ST_WR_HI   = 3'd2,
        ST_RD_LO   = 3'd3,
        ST_RD_LO_W = 3'd4,
        ST_RD_HI   = 3'd5,
        ST_RD_HI_W = 3'd6,
        ST_ACK     = 3'd7
    } vic_state_e;

    localparam int VIC_NIBBLES   = 32;
    localparam int VIC_BYTE_REGS = 16;

    // Byte register n occupies nibble 2n (bits 3:0) and nibble 2n+1 (bits 7:4).
    function automatic logic [4:0] vic_nibble_addr(input logic [3:0] byte_idx,
                                                   input logic       hi_sel);
        return {byte_idx, hi_sel};
    endfunction

endpackage

// File: rtl/vic_reg_bridge.sv
// vic_reg_bridge: turns one byte-wide CPU register access into two sequenced
// nibble accesses (low nibble first, then high nibble) on the VIC register port.
//
// Ports:
//   clk, rst          : clock (rising edge) and asynchronous active-low reset
//   i_cpu_req         : single-cycle request strobe, only honoured in IDLE
//   i_cpu_wr          : 1 = write, 0 = read
//   i_cpu_addr        : byte register index 0..15
//   i_cpu_wdata       : write byte
//   o_cpu_rdata       : last completed read byte (held until the next read ends)
//   o_cpu_ack         : one-cycle completion pulse
//   o_busy            : high whenever the FSM is not IDLE
//   o_VIC_regaddr     : nibble address
//   o_VIC_data        : write nibble
//   i_VIC_data        : read nibble, valid READ_LAT cycles after the re cycle
//   o_VIC_we/o_VIC_re : nibble write / read enables
//
// Every output is a register loaded from the next-state decode, so nothing on
// the CPU side reaches an output combinationally.
module vic_reg_bridge
    import vic_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_cpu_req,
    input  logic                               i_cpu_wr,
    input  logic [$clog2(VIC_BYTE_REGS)-1:0]   i_cpu_addr,
    input  logic [7:0]                         i_cpu_wdata,
    output logic [7:0]                         o_cpu_rdata,
    output logic                               o_cpu_ack,
    output logic                               o_busy,
    output logic [$clog2(VIC_NIBBLES)-1:0]     o_VIC_regaddr,
    output logic [3:0]                         o_VIC_data,
    input  logic [3:0]                         i_VIC_data,
    output logic                               o_VIC_we,
    output logic                               o_VIC_re
);

    // Terminal value of the 2-bit wait counter (READ_LAT is 1..3).
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    vic_state_e  state_r;
    vic_state_e  next_state_s;
    logic [3:0]  addr_r;
    logic [7:0]  wdata_r;
    logic [1:0]  wait_cnt_r;
    logic [3:0]  cap_lo_r;
    logic        in_wait_s;
    logic        wait_last_s;

    // Wait-state qualifiers shared by next-state and capture logic.
    always_comb begin
        in_wait_s   = (state_r == ST_RD_LO_W) || (state_r == ST_RD_HI_W);
        wait_last_s = in_wait_s && (wait_cnt_r == WAIT_LAST);
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_cpu_req) begin
                    if (i_cpu_wr) begin
                        next_state_s = ST_WR_LO;
                    end else begin
                        next_state_s = ST_RD_LO;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WR_LO:   next_state_s = ST_WR_HI;
            ST_WR_HI:   next_state_s = ST_ACK;
            ST_RD_LO:   next_state_s = ST_RD_LO_W;
            ST_RD_LO_W: begin
                if (wait_last_s) begin
                    next_state_s = ST_RD_HI;
                end else begin
                    next_state_s = ST_RD_LO_W;
                end
            end
            ST_RD_HI:   next_state_s = ST_RD_HI_W;
            ST_RD_HI_W: begin
                if (wait_last_s) begin
                    next_state_s = ST_ACK;
                end else begin
                    next_state_s = ST_RD_HI_W;
                end
            end
            ST_ACK:     next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch: address and write byte captured when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= 4'h0;
            wdata_r <= 8'h00;
        end else if ((state_r == ST_IDLE) && i_cpu_req) begin
            addr_r  <= i_cpu_addr;
            wdata_r <= i_cpu_wdata;
        end
    end

    // Read latency counter: cleared on entry to a wait state, counts to WAIT_LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 2'd0;
        end else if (in_wait_s && !wait_last_s) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
        end else begin
            wait_cnt_r <= 2'd0;
        end
    end

    // Nibble capture; the high nibble goes straight into o_cpu_rdata on ACK entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_lo_r    <= 4'h0;
            o_cpu_rdata <= 8'h00;
        end else begin
            if ((state_r == ST_RD_LO_W) && wait_last_s) begin
                cap_lo_r <= i_VIC_data;
            end
            if ((state_r == ST_RD_HI_W) && wait_last_s) begin
                o_cpu_rdata <= {i_VIC_data, cap_lo_r};
            end
        end
    end

    // Registered control outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_busy    <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_VIC_we  <= 1'b0;
            o_VIC_re  <= 1'b0;
        end else begin
            o_busy    <= (next_state_s != ST_IDLE);
            o_cpu_ack <= (next_state_s == ST_ACK);
            o_VIC_we  <= (next_state_s == ST_WR_LO) || (next_state_s == ST_WR_HI);
            o_VIC_re  <= (next_state_s == ST_RD_LO) || (next_state_s == ST_RD_HI);
        end
    end

    // Nibble address/data; the low-nibble states are only entered from IDLE,
    // so they take the request fields directly. Held while no enable is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_VIC_regaddr <= 5'd0;
            o_VIC_data    <= 4'h0;
        end else begin
            case (next_state_s)
                ST_WR_LO: begin
                    o_VIC_regaddr <= vic_nibble_addr(i_cpu_addr, 1'b0);
                    o_VIC_data    <= i_cpu_wdata[3:0];
                end
                ST_WR_HI: begin
                    o_VIC_regaddr <= vic_nibble_addr(addr_r, 1'b1);
                    o_VIC_data    <= wdata_r[7:4];
                end
                ST_RD_LO: begin
                    o_VIC_regaddr <= vic_nibble_addr(i_cpu_addr, 1'b0);
                end
                ST_RD_HI: begin
                    o_VIC_regaddr <= vic_nibble_addr(addr_r, 1'b1);
                end
                default: begin
                    o_VIC_regaddr <= o_VIC_regaddr;
                    o_VIC_data    <= o_VIC_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vic_reg_bridge.sv
// Directed testbench for vic_reg_bridge with a behavioural nibble register file
// (READ_LAT = 1: read data appears the cycle after the re cycle).
module tb_vic_reg_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_cpu_req = 1'b0;
    logic       i_cpu_wr = 1'b0;
    logic [3:0] i_cpu_addr = 4'h0;
    logic [7:0] i_cpu_wdata = 8'h00;
    logic [7:0] o_cpu_rdata;
    logic       o_cpu_ack;
    logic       o_busy;
    logic [4:0] o_VIC_regaddr;
    logic [3:0] o_VIC_data;
    logic [3:0] vic_rdata = 4'h0;
    logic       o_VIC_we;
    logic       o_VIC_re;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    vic_reg_bridge #(.READ_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cpu_req     (i_cpu_req),
        .i_cpu_wr      (i_cpu_wr),
        .i_cpu_addr    (i_cpu_addr),
        .i_cpu_wdata   (i_cpu_wdata),
        .o_cpu_rdata   (o_cpu_rdata),
        .o_cpu_ack     (o_cpu_ack),
        .o_busy        (o_busy),
        .o_VIC_regaddr (o_VIC_regaddr),
        .o_VIC_data    (o_VIC_data),
        .i_VIC_data    (vic_rdata),
        .o_VIC_we      (o_VIC_we),
        .o_VIC_re      (o_VIC_re)
    );

    // Register file model plus pulse / hit counters.
    logic [3:0] mem [0:31] = '{default: 4'h0};
    int we_cnt = 0, re_cnt = 0, ack_cnt = 0, both_cnt = 0;
    int wr_hits [0:31] = '{default: 0};
    int rd_hits [0:31] = '{default: 0};

    always @(posedge clk) begin
        if (o_VIC_we) begin
            mem[o_VIC_regaddr]     <= o_VIC_data;
            wr_hits[o_VIC_regaddr] <= wr_hits[o_VIC_regaddr] + 1;
            we_cnt                 <= we_cnt + 1;
        end
        if (o_VIC_re) begin
            vic_rdata              <= mem[o_VIC_regaddr];
            rd_hits[o_VIC_regaddr] <= rd_hits[o_VIC_regaddr] + 1;
            re_cnt                 <= re_cnt + 1;
        end
        if (o_cpu_ack) ack_cnt <= ack_cnt + 1;
        if (o_VIC_we && o_VIC_re) both_cnt <= both_cnt + 1;
    end

    logic [12:0] obs;
    logic [12:0] exp13;
    logic [8:0]  obs9;
    logic [8:0]  exp9;

    // Presents a request for one cycle; returns #1 after the accepting edge (cycle 1).
    task automatic issue(input logic wr, input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        i_cpu_req   = 1'b1;
        i_cpu_wr    = wr;
        i_cpu_addr  = addr;
        i_cpu_wdata = data;
        @(posedge clk);
        #1;
        i_cpu_req   = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
        issue(1'b1, addr, data);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [7:0] data, output bit ok);
        issue(1'b0, addr, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (o_cpu_ack) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        data = o_cpu_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            obs = {o_cpu_ack, o_busy, o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data};
            total++;
            if (obs !== 13'h0 || o_cpu_rdata !== 8'h00)
                $display("FAIL reset_idle c%0d obs=%h rdata=%h expected obs=0000 rdata=00", c, obs, o_cpu_rdata);
            else passed++;
        end
    endtask

    task automatic test_write();
        logic [12:0] exp_seq [0:3];
        exp_seq[0] = {1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 4'h7};
        exp_seq[1] = {1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 4'hA};
        exp_seq[2] = {1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 4'hA};
        exp_seq[3] = {1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 4'hA};
        issue(1'b1, 4'h5, 8'hA7);
        for (int c = 0; c < 4; c++) begin
            obs   = {o_cpu_ack, o_busy, o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data};
            exp13 = exp_seq[c];
            total++;
            if (obs !== exp13)
                $display("FAIL write_c%0d obs=%h expected=%h", c + 1, obs, exp13);
            else passed++;
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if ({mem[11], mem[10]} !== 8'hA7)
            $display("FAIL write_mem byte5=%h expected=a7", {mem[11], mem[10]});
        else passed++;
    endtask

    task automatic test_read_after_write();
        logic [8:0] exp_seq [0:5];
        exp_seq[0] = {1'b0, 1'b1, 1'b0, 1'b1, 5'd10};
        exp_seq[1] = {1'b0, 1'b1, 1'b0, 1'b0, 5'd10};
        exp_seq[2] = {1'b0, 1'b1, 1'b0, 1'b1, 5'd11};
        exp_seq[3] = {1'b0, 1'b1, 1'b0, 1'b0, 5'd11};
        exp_seq[4] = {1'b1, 1'b1, 1'b0, 1'b0, 5'd11};
        exp_seq[5] = {1'b0, 1'b0, 1'b0, 1'b0, 5'd11};
        issue(1'b0, 4'h5, 8'h00);
        for (int c = 0; c < 6; c++) begin
            obs9 = {o_cpu_ack, o_busy, o_VIC_we, o_VIC_re, o_VIC_regaddr};
            exp9 = exp_seq[c];
            total++;
            if (obs9 !== exp9)
                $display("FAIL read_c%0d obs=%h expected=%h", c + 1, obs9, exp9);
            else passed++;
            if (c == 4) begin
                total++;
                if (o_cpu_rdata !== 8'hA7)
                    $display("FAIL read_rdata got=%h expected=a7", o_cpu_rdata);
                else passed++;
            end
            if (c < 5) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (o_cpu_rdata !== 8'hA7)
            $display("FAIL read_hold got=%h expected=a7", o_cpu_rdata);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_b [0:15];
        int wr0 [0:31];
        int rd0 [0:31];
        int bad_wr, bad_rd, bad_data;
        logic [7:0] got;
        bit ok;
        for (int n = 0; n < 32; n++) begin
            wr0[n] = wr_hits[n];
            rd0[n] = rd_hits[n];
        end
        for (int a = 0; a < 16; a++) begin
            exp_b[a] = 8'($urandom_range(0, 255));
            do_write(4'(a), exp_b[a]);
        end
        bad_data = 0;
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), got, ok);
            if (!ok || got !== exp_b[a]) begin
                bad_data++;
                $display("FAIL sweep_byte%0d got=%h expected=%h ack_seen=%0d", a, got, exp_b[a], ok);
            end
        end
        total++;
        if (bad_data == 0) passed++;
        bad_wr = 0;
        bad_rd = 0;
        for (int n = 0; n < 32; n++) begin
            if (wr_hits[n] - wr0[n] != 1) bad_wr++;
            if (rd_hits[n] - rd0[n] != 1) bad_rd++;
        end
        total++;
        if (bad_wr != 0) $display("FAIL sweep_wr_hits nibbles_off=%0d expected=0", bad_wr);
        else passed++;
        total++;
        if (bad_rd != 0) $display("FAIL sweep_rd_hits nibbles_off=%0d expected=0", bad_rd);
        else passed++;
    endtask

    task automatic test_busy_drop();
        int ack0, we0, re0;
        ack0 = ack_cnt;
        we0  = we_cnt;
        re0  = re_cnt;
        issue(1'b1, 4'h3, 8'h5C);
        @(posedge clk);
        #1;
        // cycle 2 (WR_HI): present a read request
        i_cpu_req  = 1'b1;
        i_cpu_wr   = 1'b0;
        i_cpu_addr = 4'h7;
        @(posedge clk);
        #1;
        // cycle 3 (ACK): request still present
        total++;
        if (o_cpu_ack !== 1'b1 || o_busy !== 1'b1)
            $display("FAIL busy_ack_cycle ack=%b busy=%b expected ack=1 busy=1", o_cpu_ack, o_busy);
        else passed++;
        @(posedge clk);
        #1;
        i_cpu_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (ack_cnt - ack0 != 1) $display("FAIL busy_acks got=%0d expected=1", ack_cnt - ack0);
        else passed++;
        total++;
        if (we_cnt - we0 != 2 || re_cnt - re0 != 0)
            $display("FAIL busy_pulses we=%0d re=%0d expected we=2 re=0", we_cnt - we0, re_cnt - re0);
        else passed++;
        total++;
        if ({mem[7], mem[6]} !== 8'h5C || o_busy !== 1'b0)
            $display("FAIL busy_mem byte3=%h busy=%b expected byte3=5c busy=0", {mem[7], mem[6]}, o_busy);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] got;
        bit ok;
        do_write(4'h9, 8'h12);
        issue(1'b1, 4'h9, 8'hEF);
        @(posedge clk);
        #1;
        // cycle 2: WR_HI, high nibble not yet written
        rst = 1'b0;
        #1;
        obs = {o_cpu_ack, o_busy, o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data};
        total++;
        if (obs !== 13'h0 || o_cpu_rdata !== 8'h00)
            $display("FAIL midrst_outputs obs=%h rdata=%h expected obs=0000 rdata=00", obs, o_cpu_rdata);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        total++;
        if ({mem[19], mem[18]} !== 8'h1F)
            $display("FAIL midrst_mem byte9=%h expected=1f", {mem[19], mem[18]});
        else passed++;
        do_read(4'h9, got, ok);
        total++;
        if (!ok || got !== 8'h1F)
            $display("FAIL midrst_read got=%h ack_seen=%0d expected=1f", got, ok);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_after_write();
        test_sweep();
        test_busy_drop();
        test_reset_mid_write();
        total++;
        if (both_cnt != 0) $display("FAIL we_re_overlap cycles=%0d expected=0", both_cnt);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
